// File: rtl/psg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | psg_pkg                                                                     |
// | Shared PSG definitions: channel count, bus defaults, fetch FSM states.     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package psg_pkg;

   localparam int c_psg_nch = 8;
   localparam int c_psg_chw = $clog2(c_psg_nch);
   localparam int c_psg_aw  = 24;
   localparam int c_psg_dw  = 12;
   localparam int c_psg_tmo = 255;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } psg_state_t;

endpackage
`default_nettype wire

// File: rtl/psg_bus_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | psg_bus_timer                                                               |
// | Counts bus wait cycles; expire flags the cycle on which the count hits TMO.|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module psg_bus_timer
   import psg_pkg::*;
#(
   parameter int TMO = c_psg_tmo
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int              c_cw   = $clog2(TMO + 1);
   localparam logic [c_cw-1:0] c_last = c_cw'(TMO - 1);
   localparam logic [c_cw-1:0] c_one  = c_cw'(1);

   logic [c_cw-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= r_cnt + c_one;
      end
   end

   // The increment that lands on TMO is the abort edge.
   assign expire = en && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/psg_wave_fetch.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | psg_wave_fetch                                                              |
// | Fetches one wave sample per arbiter grant over a single-outstanding bus.   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module psg_wave_fetch
   import psg_pkg::*;
#(
   parameter int AW  = c_psg_aw,
   parameter int DW  = c_psg_dw,
   parameter int TMO = c_psg_tmo
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic [c_psg_nch-1:0] req,
   input  logic [c_psg_nch-1:0] sel,
   input  logic [c_psg_chw-1:0] seln,
   input  logic [AW-1:0]        adr_i,
   output logic                 ack_arb,
   output logic                 cyc_o,
   output logic                 stb_o,
   output logic [AW-1:0]        adr_o,
   input  logic [DW-1:0]        dat_i,
   input  logic                 ack_i,
   output logic [DW-1:0]        dat_o,
   output logic [c_psg_nch-1:0] dat_vld,
   output logic                 err,
   output logic [c_psg_chw-1:0] err_ch
);

   psg_state_t           r_state;
   psg_state_t           w_state_nxt;
   logic                 r_ce_q;
   logic [c_psg_chw-1:0] r_ch;
   logic [AW-1:0]        r_adr;
   logic [DW-1:0]        r_dat;
   logic [c_psg_nch-1:0] r_dat_vld;
   logic                 r_err;
   logic [c_psg_chw-1:0] r_err_ch;

   logic                 w_start;
   logic                 w_done;
   logic                 w_wait;
   logic                 w_expire;
   logic [c_psg_nch-1:0] w_ch_onehot;

   // A held grant whose request has dropped must not start a cycle.
   assign w_start     = (r_state == ST_IDLE) && r_ce_q && (|(sel & req));
   assign w_done      = (r_state == ST_BUS) && ack_i;
   assign w_wait      = (r_state == ST_BUS) && !ack_i;
   assign w_ch_onehot = {{(c_psg_nch-1){1'b0}}, 1'b1} << r_ch;

   psg_bus_timer #(
      .TMO    (TMO)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_start),
      .en     (w_wait),
      .expire (w_expire)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_start) w_state_nxt = ST_BUS;
         ST_BUS:  if (w_done || w_expire) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_ce_q  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ce_q  <= ce;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ch      <= '0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_dat_vld <= '0;
         r_err     <= 1'b0;
         r_err_ch  <= '0;
      end else begin
         r_dat_vld <= '0;
         r_err     <= 1'b0;
         if (w_start) begin
            r_ch  <= seln;
            r_adr <= adr_i;
         end
         if (w_done) begin
            r_dat     <= dat_i;
            r_dat_vld <= w_ch_onehot;
         end
         if (w_expire) begin
            r_err    <= 1'b1;
            r_err_ch <= r_ch;
         end
      end
   end

   assign ack_arb = (r_state == ST_IDLE);
   assign cyc_o   = (r_state == ST_BUS);
   assign stb_o   = (r_state == ST_BUS);
   assign adr_o   = r_adr;
   assign dat_o   = r_dat;
   assign dat_vld = r_dat_vld;
   assign err     = r_err;
   assign err_ch  = r_err_ch;

endmodule
`default_nettype wire
